bcpu_ibus_unit: RTL and testbench
=================================

// Module: bcpu_ibus_unit
// PURPOSE
//  Execution unit for BCPU16 bus instructions 0_0011 (IN / OUT / WAITE / WAITNE) of the barrel core.
//  - Sits downstream of decode/register read: takes bus_wr_op_t, i3, Ra, Rb and thread id.
//  - Produces register write-back, Z flag update and a RETRY indication back to the barrel pipeline.
//  - Owns the 8 output bus registers and synchronizes the 8 external input buses.
// PARAMETERS
//  DATA_WIDTH   16  bus / register width
//  THREAD_BITS  2   thread id width (4 barrel threads)
//  SYNC_STAGES  2   flip-flop stages on BUS_IN (>=1)
//  WAIT_LIMIT   0   max failed WAITE/WAITNE retries per thread before timeout; 0 = never time out
// PORTS
//  CLK          in   1              core clock
//  RESET_N      in   1              async active-low reset
//  IN_VALID     in   1              bus instruction presented this cycle
//  IN_THREAD    in   THREAD_BITS    issuing thread
//  IN_OP        in   2              bus_wr_op_t (READ/WRITE/WAITE/WAITNE)
//  IN_BUS_IDX   in   3              i3, bus index 0..7
//  IN_A         in   DATA_WIDTH     Ra: WRITE data / WAIT compare value; ignored by READ
//  IN_MASK      in   DATA_WIDTH     Rb mask
//  OUT_VALID    out  1              result for one instruction
//  OUT_THREAD   out  THREAD_BITS    thread of result
//  OUT_WR_EN    out  1              write OUT_DATA to Rd (READ only)
//  OUT_DATA     out  DATA_WIDTH     READ result
//  OUT_FLAG_EN  out  1              update Z flag (READ only)
//  OUT_ZFLAG    out  1              Z value when OUT_FLAG_EN
//  OUT_RETRY    out  1              wait not satisfied: thread must re-issue, PC unchanged
//  OUT_TIMEOUT  out  1              wait abandoned after WAIT_LIMIT retries; PC advances
//  BUS_IN       in   8*DATA_WIDTH   external input buses, asynchronous to CLK
//  BUS_OUT      out  8*DATA_WIDTH   output bus registers
// BEHAVIOUR
//  - Reset, async: all OUT_* = 0, BUS_OUT = 0, sync flops = 0, retry counters = 0, stage valids = 0.
//  - BUS_IN[k] passes through a SYNC_STAGES-deep flop chain; syncin[k] is the last stage.
//  - Pipeline: S1 registers IN_* (when IN_VALID); S2 computes; OUT_* registered at end of S2.
//    Latency 2 clocks. Throughput 1 op/clock. No backpressure. OUT_* are valid-qualified, 1-cycle pulses.
//  - READ:   OUT_DATA = syncin[idx] & mask, sampled in S2. OUT_WR_EN = OUT_FLAG_EN = 1, OUT_ZFLAG = (OUT_DATA == 0).
//  - WRITE:  BUS_OUT[idx] <= (BUS_OUT[idx] & ~mask) | (A & mask) at end of S2. Computed from the current
//            register value, so back-to-back WRITEs to one bus compose. No flags, no reg write.
//  - WAITE:  done = ((syncin[idx] & mask) == (A & mask)).
//  - WAITNE: done = ((syncin[idx] & mask) != (A & mask)).
//  - Wait handling, per-thread counter cnt[t] (width clog2(WAIT_LIMIT+1)):
//    - done: OUT_RETRY = 0, cnt[t] <= 0.
//    - not done, and (WAIT_LIMIT == 0 or cnt[t] < WAIT_LIMIT): OUT_RETRY = 1, cnt[t] <= cnt[t] + 1.
//      Counter is not incremented when WAIT_LIMIT == 0.
//    - not done, and WAIT_LIMIT != 0 and cnt[t] == WAIT_LIMIT: OUT_TIMEOUT = 1, OUT_RETRY = 0, cnt[t] <= 0.
//    - READ and WRITE also clear cnt[t].
//  - Mask 0: READ returns 0 with Z = 1; WAITE is always done; WAITNE never completes (times out only if WAIT_LIMIT != 0).
//  - READ / WAIT observe syncin only, never BUS_OUT. No forwarding between WRITE and READ on the same index.
//  - Reset mid-pipeline drops in-flight ops; no OUT_VALID is produced for them.
// TESTING
//  1. READ idx3, BUS_IN[3] = 16'hA5F0, mask 16'h0FF0, held 4 clks
//     -> OUT_DATA = 16'h05F0, WR_EN = 1, Z = 0, 2 clks after issue (sync settled).
//  2. BUS_OUT[1] = 16'h00FF; WRITE idx1 A = 16'hFFFF mask 16'hF000, then next clk WRITE A = 0 mask 16'h000F
//     -> BUS_OUT[1] = 16'hF0FF, then 16'hF0F0.
//  3. WAITE idx0 A = 1 mask 1, BUS_IN[0] = 0 -> OUT_RETRY = 1 on each issue;
//     set BUS_IN[0] = 1 -> after sync, RETRY = 0, counter cleared.
//  4. WAIT_LIMIT = 3, WAITNE mask 16'hFFFF A == BUS_IN, reissued every clk
//     -> 3 RETRY pulses, then TIMEOUT = 1 on the 4th.
//  5. Threads 0..3 issue interleaved WAITE ops, only thread 2 satisfied
//     -> OUT_THREAD tags correct; only thread 2 gets RETRY = 0; other counters independent.
//  6. Assert RESET_N low with ops in S1/S2 -> no OUT_VALID, BUS_OUT = 0 immediately (async).

Source files
------------

// File: rtl/bcpu_ibus_unit.sv
// bcpu_ibus_unit: BCPU16 bus-instruction unit (IN / OUT / WAITE / WAITNE).
// Owns the output bus registers and synchronizes the external input buses.
module bcpu_ibus_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int THREAD_BITS = 2,
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_LIMIT  = 0
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    IN_VALID,
    input  logic [THREAD_BITS-1:0]  IN_THREAD,
    input  logic [1:0]              IN_OP,
    input  logic [2:0]              IN_BUS_IDX,
    input  logic [DATA_WIDTH-1:0]   IN_A,
    input  logic [DATA_WIDTH-1:0]   IN_MASK,
    output logic                    OUT_VALID,
    output logic [THREAD_BITS-1:0]  OUT_THREAD,
    output logic                    OUT_WR_EN,
    output logic [DATA_WIDTH-1:0]   OUT_DATA,
    output logic                    OUT_FLAG_EN,
    output logic                    OUT_ZFLAG,
    output logic                    OUT_RETRY,
    output logic                    OUT_TIMEOUT,
    input  logic [8*DATA_WIDTH-1:0] BUS_IN,
    output logic [8*DATA_WIDTH-1:0] BUS_OUT
);

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_WAITE  = 2'd2,
        OP_WAITNE = 2'd3
    } bus_wr_op_t;

    localparam int NT = 1 << THREAD_BITS;
    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    logic [8*DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0]   sync_word [8];
    logic [DATA_WIDTH-1:0]   bus_q [8];
    logic [CW-1:0]           cnt [NT];

    logic                   s1_valid;
    logic [THREAD_BITS-1:0] s1_thread;
    bus_wr_op_t             s1_op;
    logic [2:0]             s1_idx;
    logic [DATA_WIDTH-1:0]  s1_a;
    logic [DATA_WIDTH-1:0]  s1_mask;

    logic [DATA_WIDTH-1:0] s2_data;
    logic [DATA_WIDTH-1:0] s2_wdata;
    logic                  s2_match;
    logic                  is_read;
    logic                  is_write;
    logic                  is_wait;
    logic                  done;
    logic                  expired;
    logic [CW-1:0]         cur_cnt;
    logic [CW-1:0]         next_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= BUS_IN;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            sync_word[k] = sync_q[SYNC_STAGES-1][k*DATA_WIDTH +: DATA_WIDTH];
            BUS_OUT[k*DATA_WIDTH +: DATA_WIDTH] = bus_q[k];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_valid  <= 1'b0;
            s1_thread <= '0;
            s1_op     <= OP_READ;
            s1_idx    <= '0;
            s1_a      <= '0;
            s1_mask   <= '0;
        end else begin
            s1_valid <= IN_VALID;
            if (IN_VALID) begin
                s1_thread <= IN_THREAD;
                s1_op     <= bus_wr_op_t'(IN_OP);
                s1_idx    <= IN_BUS_IDX;
                s1_a      <= IN_A;
                s1_mask   <= IN_MASK;
            end
        end
    end

    always_comb begin
        s2_data  = sync_word[s1_idx] & s1_mask;
        s2_match = (s2_data == (s1_a & s1_mask));
        s2_wdata = (bus_q[s1_idx] & ~s1_mask) | (s1_a & s1_mask);
        cur_cnt  = cnt[s1_thread];
        is_read  = 1'b0;
        is_write = 1'b0;
        is_wait  = 1'b0;
        done     = 1'b1;
        unique case (s1_op)
            OP_READ:   is_read = 1'b1;
            OP_WRITE:  is_write = 1'b1;
            OP_WAITE: begin
                is_wait = 1'b1;
                done    = s2_match;
            end
            OP_WAITNE: begin
                is_wait = 1'b1;
                done    = !s2_match;
            end
            default: ;
        endcase
        // A zero limit disables the timeout entirely.
        expired = (WAIT_LIMIT != 0) && (cur_cnt >= LIMIT);
        if (!is_wait || done || expired)
            next_cnt = '0;
        else if (WAIT_LIMIT == 0)
            next_cnt = cur_cnt;
        else
            next_cnt = cur_cnt + CW'(1);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            OUT_VALID   <= 1'b0;
            OUT_THREAD  <= '0;
            OUT_WR_EN   <= 1'b0;
            OUT_DATA    <= '0;
            OUT_FLAG_EN <= 1'b0;
            OUT_ZFLAG   <= 1'b0;
            OUT_RETRY   <= 1'b0;
            OUT_TIMEOUT <= 1'b0;
            for (int k = 0; k < 8; k++) bus_q[k] <= '0;
            for (int t = 0; t < NT; t++) cnt[t] <= '0;
        end else begin
            OUT_VALID   <= s1_valid;
            OUT_THREAD  <= s1_valid ? s1_thread : '0;
            OUT_WR_EN   <= s1_valid && is_read;
            OUT_FLAG_EN <= s1_valid && is_read;
            OUT_DATA    <= (s1_valid && is_read) ? s2_data : '0;
            OUT_ZFLAG   <= s1_valid && is_read && (s2_data == '0);
            OUT_RETRY   <= s1_valid && is_wait && !done && !expired;
            OUT_TIMEOUT <= s1_valid && is_wait && !done && expired;
            if (s1_valid) begin
                if (is_write) bus_q[s1_idx] <= s2_wdata;
                cnt[s1_thread] <= next_cnt;
            end
        end
    end

endmodule

// File: tb/tb_bcpu_ibus_unit.sv
// tb_bcpu_ibus_unit: random + directed bench for bcpu_ibus_unit
// against a cycle-indexed reference model of the bus instructions.
module tb_bcpu_ibus_unit;

    localparam int DW = 16;
    localparam int SS = 2;
    localparam int WL = 3;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          IN_VALID = 1'b0;
    logic [1:0]    IN_THREAD = '0;
    logic [1:0]    IN_OP = '0;
    logic [2:0]    IN_BUS_IDX = '0;
    logic [DW-1:0] IN_A = '0;
    logic [DW-1:0] IN_MASK = '0;
    logic          OUT_VALID;
    logic [1:0]    OUT_THREAD;
    logic          OUT_WR_EN;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_FLAG_EN;
    logic          OUT_ZFLAG;
    logic          OUT_RETRY;
    logic          OUT_TIMEOUT;
    logic [8*DW-1:0] BUS_IN = '0;
    logic [8*DW-1:0] BUS_OUT;

    always #5 CLK = ~CLK;

    bcpu_ibus_unit #(
        .DATA_WIDTH (DW),
        .THREAD_BITS(2),
        .SYNC_STAGES(SS),
        .WAIT_LIMIT (WL)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .IN_VALID   (IN_VALID),
        .IN_THREAD  (IN_THREAD),
        .IN_OP      (IN_OP),
        .IN_BUS_IDX (IN_BUS_IDX),
        .IN_A       (IN_A),
        .IN_MASK    (IN_MASK),
        .OUT_VALID  (OUT_VALID),
        .OUT_THREAD (OUT_THREAD),
        .OUT_WR_EN  (OUT_WR_EN),
        .OUT_DATA   (OUT_DATA),
        .OUT_FLAG_EN(OUT_FLAG_EN),
        .OUT_ZFLAG  (OUT_ZFLAG),
        .OUT_RETRY  (OUT_RETRY),
        .OUT_TIMEOUT(OUT_TIMEOUT),
        .BUS_IN     (BUS_IN),
        .BUS_OUT    (BUS_OUT)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [8*DW-1:0] got,
                         input logic [8*DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: BUS_IN history per cycle, bus registers, counters.
    logic [8*DW-1:0] bus_in_v = '0;
    logic [8*DW-1:0] hist [0:4095];
    int              cyc = 0;
    logic [DW-1:0]   m_out [8];
    int              m_cnt [4];

    typedef struct {
        bit         v;
        logic [1:0] th;
        logic [1:0] op;
        logic [2:0] idx;
        logic [DW-1:0] a;
        logic [DW-1:0] m;
        int         c;
    } op_t;
    op_t pend;

    logic          e_valid, e_wr, e_flag, e_z, e_retry, e_to;
    logic [1:0]    e_thread;
    logic [DW-1:0] e_data;

    function automatic logic [DW-1:0] seen(input int c, input logic [2:0] k);
        logic [8*DW-1:0] w;
        if (c < 0) return '0;
        w = hist[c];
        return w[k*DW +: DW];
    endfunction

    function automatic logic [8*DW-1:0] packed_out();
        logic [8*DW-1:0] r;
        for (int k = 0; k < 8; k++) r[k*DW +: DW] = m_out[k];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_out[k] = '0;
        for (int t = 0; t < 4; t++) m_cnt[t] = 0;
        pend.v = 0;
        cyc = 0;
    endtask

    task automatic model_step();
        logic [DW-1:0] s;
        bit done;
        e_valid = pend.v;
        {e_wr, e_flag, e_z, e_retry, e_to} = '0;
        e_thread = '0;
        e_data = '0;
        if (pend.v) begin
            // Two-flop synchronizer: op sees BUS_IN from SS-1 cycles earlier.
            s = seen(pend.c - (SS - 1), pend.idx);
            e_thread = pend.th;
            case (pend.op)
                2'd0: begin
                    e_data = s & pend.m;
                    e_wr = 1; e_flag = 1;
                    e_z = (e_data == 0);
                    m_cnt[pend.th] = 0;
                end
                2'd1: begin
                    m_out[pend.idx] = (m_out[pend.idx] & ~pend.m)
                                    | (pend.a & pend.m);
                    m_cnt[pend.th] = 0;
                end
                default: begin
                    if (pend.op == 2'd2)
                        done = ((s & pend.m) == (pend.a & pend.m));
                    else
                        done = ((s & pend.m) != (pend.a & pend.m));
                    if (done) m_cnt[pend.th] = 0;
                    else if (WL == 0 || m_cnt[pend.th] < WL) begin
                        e_retry = 1;
                        if (WL != 0) m_cnt[pend.th]++;
                    end else begin
                        e_to = 1;
                        m_cnt[pend.th] = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic tick(input bit v, input logic [1:0] th,
                        input logic [1:0] op, input logic [2:0] idx,
                        input logic [DW-1:0] a, input logic [DW-1:0] m);
        IN_VALID = v; IN_THREAD = th; IN_OP = op;
        IN_BUS_IDX = idx; IN_A = a; IN_MASK = m;
        BUS_IN = bus_in_v;
        hist[cyc] = bus_in_v;
        @(posedge CLK);
        model_step();
        pend.v = v; pend.th = th; pend.op = op;
        pend.idx = idx; pend.a = a; pend.m = m; pend.c = cyc;
        cyc++;
        @(negedge CLK);
        check("valid", OUT_VALID, e_valid);
        if (e_valid) begin
            check("thread", OUT_THREAD, e_thread);
            check("wr_en", OUT_WR_EN, e_wr);
            check("data", OUT_DATA, e_data);
            check("flag_en", OUT_FLAG_EN, e_flag);
            check("zflag", OUT_ZFLAG, e_z);
            check("retry", OUT_RETRY, e_retry);
            check("timeout", OUT_TIMEOUT, e_to);
        end
        check("bus_out", BUS_OUT, packed_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, '0, '0);
    endtask

    initial begin
        logic [DW-1:0] w;
        logic [2:0] ri;
        logic [DW-1:0] ra, rm;
        bit [1:0] exp_r [4];
        model_reset();
        #12;
        check("rst_valid", OUT_VALID, 0);
        check("rst_retry", OUT_RETRY, 0);
        check("rst_data", OUT_DATA, 0);
        check("rst_bus_out", BUS_OUT, 0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // READ with mask
        bus_in_v[3*DW +: DW] = 16'hA5F0;
        idle(2);
        tick(1, 0, 2'd0, 3'd3, 16'h1234, 16'h0FF0);
        idle(1);
        check("t1_data", OUT_DATA, 16'h05F0);
        check("t1_z", OUT_ZFLAG, 0);

        // back-to-back WRITEs compose
        tick(1, 1, 2'd1, 3'd1, 16'h00FF, 16'hFFFF);
        tick(1, 1, 2'd1, 3'd1, 16'hFFFF, 16'hF000);
        tick(1, 1, 2'd1, 3'd1, 16'h0000, 16'h000F);
        check("t2_first", BUS_OUT[1*DW +: DW], 16'hF0FF);
        idle(1);
        check("t2_second", BUS_OUT[1*DW +: DW], 16'hF0F0);

        // WAITE retry until input changes
        tick(1, 0, 2'd2, 3'd0, 16'h0001, 16'h0001);
        tick(1, 0, 2'd2, 3'd0, 16'h0001, 16'h0001);
        check("t3_retry", OUT_RETRY, 1);
        bus_in_v[0 +: DW] = 16'h0001;
        idle(2);
        tick(1, 0, 2'd2, 3'd0, 16'h0001, 16'h0001);
        idle(1);
        check("t3_done", OUT_RETRY, 0);

        // WAITNE timeout after WL retries
        bus_in_v[4*DW +: DW] = 16'h1234;
        idle(2);
        exp_r = '{2'b01, 2'b01, 2'b01, 2'b10};
        tick(1, 1, 2'd3, 3'd4, 16'h1234, 16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) tick(1, 1, 2'd3, 3'd4, 16'h1234, 16'hFFFF);
            else idle(1);
            check("t4_rt", {OUT_TIMEOUT, OUT_RETRY}, exp_r[i]);
        end

        // interleaved threads, only thread 2 satisfied
        bus_in_v[2*DW +: DW] = 16'h0055;
        idle(2);
        for (int r = 0; r < 4; r++)
            for (int t = 0; t < 4; t++)
                tick(1, 2'(t), 2'd2, 3'd2,
                     (t == 2) ? 16'h0055 : 16'h00AA, 16'h00FF);
        idle(1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) begin
                w = 16'($urandom);
                bus_in_v[$urandom_range(7)*DW +: DW] = w;
            end
            ri = 3'($urandom_range(7));
            ra = $urandom_range(1) ? bus_in_v[ri*DW +: DW] : 16'($urandom);
            case ($urandom_range(7))
                0: rm = 16'h0000;
                1: rm = 16'hFFFF;
                default: rm = 16'($urandom);
            endcase
            tick($urandom_range(4) != 0, 2'($urandom_range(3)),
                 2'($urandom_range(3)), ri, ra, rm);
        end

        // async reset with an op in flight
        tick(1, 3, 2'd1, 3'd5, 16'hBEEF, 16'hFFFF);
        idle(1);
        bus_in_v = {8{16'hC3C3}};
        BUS_IN = bus_in_v;
        IN_VALID = 1; IN_OP = 2'd1; IN_BUS_IDX = 3'd6;
        IN_A = 16'h7777; IN_MASK = 16'hFFFF;
        @(posedge CLK);
        IN_VALID = 0;
        #2;
        RESET_N = 1'b0;
        #1;
        check("rst_async_bus", BUS_OUT, 0);
        check("rst_async_valid", OUT_VALID, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rst_hold_valid", OUT_VALID, 0);
            check("rst_hold_bus", BUS_OUT, 0);
        end
        model_reset();
        RESET_N = 1'b1;
        tick(1, 2, 2'd0, 3'd6, 16'h0, 16'hFFFF);
        idle(1);
        check("rst_sync_clear", OUT_DATA, 0);
        idle(2);
        tick(1, 2, 2'd0, 3'd6, 16'h0, 16'hFFFF);
        idle(1);
        check("post_rst_read", OUT_DATA, 16'hC3C3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
